// File: rtl/ram_if_pkg.sv
// Shared definitions for the synchronous RAM master and the RAM wrapper.
package ram_if_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StAccess = 2'd1,
      StFault  = 2'd2
   } state_e;

   localparam int unsigned DEF_RD_LAT = 1;
   localparam int unsigned DEF_WR_LAT = 1;

   function automatic int unsigned lat_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ram_sync_master_if.sv
// CPU-side request/response signals plus the RAM-side strobe bus.
interface ram_sync_master_if;

   logic        req;
   logic        we;
   logic        byte_op;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ack;
   logic        err;
   logic        busy;

   logic [15:0] ram_addr;
   logic [15:0] ram_data_in;
   logic [15:0] ram_data_out;
   logic        ram_rd;
   logic        ram_wr;
   logic        ram_byte_op;

   // Master side: the bus initiator.
   modport master (
      input  req, we, byte_op, addr, wdata, ram_data_out,
      output rdata, ack, err, busy, ram_addr, ram_data_in, ram_rd, ram_wr, ram_byte_op
   );

   // Slave side: the requesting core together with the RAM.
   modport slave (
      output req, we, byte_op, addr, wdata, ram_data_out,
      input  rdata, ack, err, busy, ram_addr, ram_data_in, ram_rd, ram_wr, ram_byte_op
   );

endinterface

// File: rtl/ram_sync_master_lat_counter.sv
// Loadable down-counter; done flags the last cycle of a strobe window.
module lat_counter #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Reload on accept, otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - WIDTH'(1);
      end
   end

   assign done = (count == WIDTH'(1));

endmodule

// File: rtl/ram_sync_master.sv
// Bus initiator for the synchronous 16-bit RAM with odd-address word trapping.
module ram_sync_master
   import ram_if_pkg::*;
#(
   parameter int unsigned RD_LAT = DEF_RD_LAT,
   parameter int unsigned WR_LAT = DEF_WR_LAT
) (
   input logic               clk,
   input logic               reset_n,
   ram_sync_master_if.master bus
);

   localparam int unsigned CNT_W = $clog2(lat_max(RD_LAT, WR_LAT) + 1);

   state_e           state;
   logic             accept;
   logic             odd_word;
   logic             cnt_done;
   logic [CNT_W-1:0] cnt_load_val;

   // ack low in IDLE guarantees a gap cycle even when req is held high.
   assign accept       = (state == StIdle) && bus.req && !bus.ack;
   assign odd_word     = !bus.byte_op && bus.addr[0];
   assign cnt_load_val = bus.we ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);

   lat_counter #(
      .WIDTH (CNT_W)
   ) u_lat_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (accept),
      .load_val (cnt_load_val),
      .en       (state == StAccess),
      .done     (cnt_done)
   );

   // FSM with registered strobes, response and captured read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= StIdle;
         bus.ack         <= 1'b0;
         bus.err         <= 1'b0;
         bus.busy        <= 1'b0;
         bus.rdata       <= '0;
         bus.ram_addr    <= '0;
         bus.ram_data_in <= '0;
         bus.ram_rd      <= 1'b0;
         bus.ram_wr      <= 1'b0;
         bus.ram_byte_op <= 1'b0;
      end else begin
         bus.ack <= 1'b0;
         bus.err <= 1'b0;
         unique case (state)
            StIdle: begin
               bus.busy <= accept;
               if (accept) begin
                  bus.ram_addr    <= bus.addr;
                  bus.ram_byte_op <= bus.byte_op;
                  // Byte writes replicate the low byte; the RAM picks the lane.
                  bus.ram_data_in <= bus.byte_op ? {bus.wdata[7:0], bus.wdata[7:0]} : bus.wdata;
                  if (odd_word) begin
                     state   <= StFault;
                     bus.ack <= 1'b1;
                     bus.err <= 1'b1;
                  end else begin
                     state      <= StAccess;
                     bus.ram_rd <= !bus.we;
                     bus.ram_wr <= bus.we;
                  end
               end
            end
            StAccess: begin
               if (cnt_done) begin
                  state      <= StIdle;
                  bus.ram_rd <= 1'b0;
                  bus.ram_wr <= 1'b0;
                  bus.ack    <= 1'b1;
                  if (bus.ram_rd) begin
                     if (bus.ram_byte_op) begin
                        bus.rdata <= {8'h00, bus.ram_addr[0] ? bus.ram_data_out[15:8]
                                                             : bus.ram_data_out[7:0]};
                     end else begin
                        bus.rdata <= bus.ram_data_out;
                     end
                  end
               end
            end
            StFault: begin
               state    <= StIdle;
               bus.busy <= 1'b0;
            end
            default: begin
               state    <= StIdle;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_sync_master.sv
// Bench for ram_sync_master: latency-1 and latency-3 instances sharing one RAM model.
module tb_ram_sync_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        sel;
   logic        req, we, byte_op;
   logic [15:0] addr, wdata;

   logic [15:0] rdata, ram_addr, ram_data_in, ram_data_out;
   logic        ack, err, busy, ram_rd, ram_wr, ram_byte_op;

   ram_sync_master_if bus1 ();
   ram_sync_master_if bus3 ();

   ram_sync_master #(.RD_LAT(1), .WR_LAT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
   ram_sync_master #(.RD_LAT(3), .WR_LAT(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

   assign bus1.req          = req & ~sel;
   assign bus1.we           = we;
   assign bus1.byte_op      = byte_op;
   assign bus1.addr         = addr;
   assign bus1.wdata        = wdata;
   assign bus1.ram_data_out = ram_data_out;
   assign bus3.req          = req & sel;
   assign bus3.we           = we;
   assign bus3.byte_op      = byte_op;
   assign bus3.addr         = addr;
   assign bus3.wdata        = wdata;
   assign bus3.ram_data_out = ram_data_out;

   assign rdata       = sel ? bus3.rdata       : bus1.rdata;
   assign ack         = sel ? bus3.ack         : bus1.ack;
   assign err         = sel ? bus3.err         : bus1.err;
   assign busy        = sel ? bus3.busy        : bus1.busy;
   assign ram_addr    = sel ? bus3.ram_addr    : bus1.ram_addr;
   assign ram_data_in = sel ? bus3.ram_data_in : bus1.ram_data_in;
   assign ram_rd      = sel ? bus3.ram_rd      : bus1.ram_rd;
   assign ram_wr      = sel ? bus3.ram_wr      : bus1.ram_wr;
   assign ram_byte_op = sel ? bus3.ram_byte_op : bus1.ram_byte_op;

   // RAM model: combinational read, lane-selected byte writes, optional data override.
   logic [15:0] ram_mem [32768];
   logic        ovr_en;
   logic [15:0] ovr_val;
   assign ram_data_out = ovr_en ? ovr_val : ram_mem[ram_addr[15:1]];

   always @(posedge clk) begin
      if (ram_wr) begin
         if (!ram_byte_op)     ram_mem[ram_addr[15:1]]       <= ram_data_in;
         else if (ram_addr[0]) ram_mem[ram_addr[15:1]][15:8] <= ram_data_in[15:8];
         else                  ram_mem[ram_addr[15:1]][7:0]  <= ram_data_in[7:0];
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check16(name, {15'd0, act}, {15'd0, exp});
   endtask

   // Reference model: byte-addressed little-endian memory plus last rdata per instance.
   logic [7:0]  ref_mem [65536];
   logic [15:0] last_rd [2];

   task automatic model(input logic s, input logic w, input logic b, input logic [15:0] a,
                        input logic [15:0] d, output logic [15:0] e_rd, output logic e_err,
                        output logic [15:0] e_din);
      int lo, hi;
      lo    = int'(a) & 32'hFFFE;
      hi    = lo + 1;
      e_err = !b && a[0];
      e_din = b ? {d[7:0], d[7:0]} : d;
      e_rd  = last_rd[s];
      if (!e_err) begin
         if (w) begin
            if (b) ref_mem[int'(a)] = d[7:0];
            else begin
               ref_mem[lo] = d[7:0];
               ref_mem[hi] = d[15:8];
            end
         end else begin
            e_rd = b ? {8'h00, ref_mem[int'(a)]} : {ref_mem[hi], ref_mem[lo]};
            last_rd[s] = e_rd;
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check1({tag, " ack"}, ack, 1'b0);
      check1({tag, " err"}, err, 1'b0);
      check1({tag, " busy"}, busy, 1'b0);
      check1({tag, " ram_rd"}, ram_rd, 1'b0);
      check1({tag, " ram_wr"}, ram_wr, 1'b0);
      check1({tag, " ram_byte_op"}, ram_byte_op, 1'b0);
      check16({tag, " ram_addr"}, ram_addr, 16'h0000);
      check16({tag, " ram_data_in"}, ram_data_in, 16'h0000);
      check16({tag, " rdata"}, rdata, 16'h0000);
   endtask

   // One request, from drive through the ack cycle and the following idle cycle.
   task automatic run_txn(input logic s, input logic w, input logic b, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] e_rd, input logic e_err,
                          input logic [15:0] e_din, input string name);
      int lat, rd_cnt, wr_cnt, n_wait;
      bit got_ack, seen_strobe;
      lat = e_err ? 0 : (s ? 3 : 1);
      rd_cnt = 0; wr_cnt = 0; n_wait = 0; got_ack = 0; seen_strobe = 0;
      sel = s;
      #1;
      while ((busy || ack) && n_wait < 20) begin
         @(posedge clk); #1;
         n_wait++;
      end
      if (n_wait >= 20) check1({name, " idle timeout"}, 1'b0, 1'b1);
      we = w; byte_op = b; addr = a; wdata = d; req = 1'b1;
      for (int c = 0; c < 12 && !got_ack; c++) begin
         @(posedge clk); #1;
         if (c == 0) check1({name, " busy"}, busy, 1'b1);
         rd_cnt += int'(ram_rd);
         wr_cnt += int'(ram_wr);
         if ((ram_rd || ram_wr) && !seen_strobe) begin
            seen_strobe = 1;
            check16({name, " ram_addr"}, ram_addr, a);
            check1({name, " ram_byte_op"}, ram_byte_op, b);
            if (w) check16({name, " ram_data_in"}, ram_data_in, e_din);
         end
         if (ack) begin
            got_ack = 1;
            check16({name, " ack latency"}, 16'(c), 16'(lat));
            check1({name, " err"}, err, e_err);
            check16({name, " rdata"}, rdata, e_rd);
         end
      end
      if (!got_ack) check1({name, " ack timeout"}, 1'b0, 1'b1);
      req = 1'b0;
      check16({name, " rd strobes"}, 16'(rd_cnt), (!w && !e_err) ? 16'(lat) : 16'd0);
      check16({name, " wr strobes"}, 16'(wr_cnt), (w && !e_err) ? 16'(lat) : 16'd0);
      @(posedge clk); #1;
      check1({name, " ack pulse"}, ack, 1'b0);
      check1({name, " busy end"}, busy, 1'b0);
   endtask

   typedef struct {
      logic        we;
      logic        byte_op;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
      logic        exp_err;
      logic [15:0] exp_din;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_vec %0d", n_vec);
      $fatal(1);
   end

   initial begin
      logic [15:0] e_rd, e_din;
      logic        e_err;
      logic        rw, rb;
      logic [15:0] ra, rd;
      int          n_ack;

      tbl[0]  = '{1'b1, 1'b0, 16'o1000, 16'o123456, 16'h0000, 1'b0, 16'o123456};
      tbl[1]  = '{1'b0, 1'b0, 16'o1000, 16'h0000,   16'o123456, 1'b0, 16'h0000};
      tbl[2]  = '{1'b1, 1'b0, 16'h0200, 16'hFFFF,   16'hA72E, 1'b0, 16'hFFFF};
      tbl[3]  = '{1'b1, 1'b1, 16'h0201, 16'h0012,   16'hA72E, 1'b0, 16'h1212};
      tbl[4]  = '{1'b0, 1'b1, 16'h0201, 16'h0000,   16'h0012, 1'b0, 16'h0000};
      tbl[5]  = '{1'b0, 1'b1, 16'h0200, 16'h0000,   16'h00FF, 1'b0, 16'h0000};
      tbl[6]  = '{1'b0, 1'b0, 16'h0200, 16'h0000,   16'h12FF, 1'b0, 16'h0000};
      tbl[7]  = '{1'b0, 1'b0, 16'h0101, 16'h0000,   16'h12FF, 1'b1, 16'h0000};
      tbl[8]  = '{1'b1, 1'b0, 16'h0103, 16'h5555,   16'h12FF, 1'b1, 16'h5555};
      tbl[9]  = '{1'b1, 1'b1, 16'h0100, 16'hAB34,   16'h12FF, 1'b0, 16'h3434};
      tbl[10] = '{1'b0, 1'b1, 16'h0101, 16'h0000,   16'h0000, 1'b0, 16'h0000};
      tbl[11] = '{1'b0, 1'b0, 16'h0100, 16'h0000,   16'h0034, 1'b0, 16'h0000};

      for (int i = 0; i < 32768; i++) ram_mem[i] = 16'h0000;
      for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
      last_rd[0] = 16'h0000;
      last_rd[1] = 16'h0000;
      reset_n = 1'b0; sel = 1'b0; req = 1'b0; we = 1'b0; byte_op = 1'b0;
      addr = '0; wdata = '0; ovr_en = 1'b0; ovr_val = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset lat1");
      sel = 1'b1; #1;
      check_reset_vals("reset lat3");
      sel = 1'b0;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors on the latency-1 instance.
      for (int i = 0; i < 12; i++) begin
         model(1'b0, tbl[i].we, tbl[i].byte_op, tbl[i].addr, tbl[i].wdata, e_rd, e_err, e_din);
         run_txn(1'b0, tbl[i].we, tbl[i].byte_op, tbl[i].addr, tbl[i].wdata,
                 tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_din, $sformatf("vec%0d", i));
      end

      // req held across three reads: one accept every LAT+2 = 3 cycles.
      sel = 1'b0; we = 1'b0; byte_op = 1'b0; addr = 16'h0200; req = 1'b1;
      n_ack = 0;
      for (int j = 0; j < 11; j++) begin
         @(posedge clk); #1;
         check1($sformatf("held ack j%0d", j), ack, (j % 3 == 1) && (j < 9));
         check1($sformatf("held busy j%0d", j), busy, (j % 3 != 2) && (j < 9));
         if (ack) begin
            n_ack++;
            check16($sformatf("held rdata j%0d", j), rdata, 16'h12FF);
            if (n_ack == 3) req = 1'b0;
         end
      end
      req = 1'b0;
      check16("held ack count", 16'(n_ack), 16'd3);
      last_rd[0] = 16'h12FF;

      // RD_LAT=3: only the data present at the final edge is captured.
      sel = 1'b1; we = 1'b0; byte_op = 1'b0; addr = 16'h0200;
      ovr_en = 1'b1; ovr_val = 16'h1111; req = 1'b1;
      @(posedge clk); #1;
      check1("lat3 rd c0", ram_rd, 1'b1);
      ovr_val = 16'h2222;
      @(posedge clk); #1;
      check1("lat3 rd c1", ram_rd, 1'b1);
      check1("lat3 ack c1", ack, 1'b0);
      ovr_val = 16'h3333;
      @(posedge clk); #1;
      check1("lat3 rd c2", ram_rd, 1'b1);
      check1("lat3 ack c2", ack, 1'b0);
      check16("lat3 rdata early", rdata, last_rd[1]);
      ovr_val = 16'h4444;
      @(posedge clk); #1;
      check1("lat3 ack c3", ack, 1'b1);
      check1("lat3 rd c3", ram_rd, 1'b0);
      check16("lat3 rdata", rdata, 16'h4444);
      req = 1'b0; ovr_en = 1'b0;
      last_rd[1] = 16'h4444;
      @(posedge clk); #1;
      check1("lat3 ack pulse", ack, 1'b0);

      // Randomised traffic against the reference model.
      for (int i = 0; i < 150; i++) begin
         sel = 1'($urandom_range(0, 1));
         rw  = 1'($urandom_range(0, 1));
         rb  = 1'($urandom_range(0, 1));
         ra  = 16'h0200 + 16'($urandom_range(0, 15));
         rd  = 16'($urandom);
         model(sel, rw, rb, ra, rd, e_rd, e_err, e_din);
         run_txn(sel, rw, rb, ra, rd, e_rd, e_err, e_din, $sformatf("rnd%0d", i));
      end

      // Reset during the second strobe cycle of a WR_LAT=3 write.
      sel = 1'b1; we = 1'b1; byte_op = 1'b0; addr = 16'h0210; wdata = 16'h5A5A; req = 1'b1;
      @(posedge clk); #1;
      check1("rst wr c0", ram_wr, 1'b1);
      @(posedge clk); #1;
      check1("rst wr c1", ram_wr, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check1("rst wr drop", ram_wr, 1'b0);
      check1("rst busy drop", busy, 1'b0);
      for (int j = 0; j < 3; j++) begin
         @(posedge clk); #1;
         check1($sformatf("rst no ack %0d", j), ack, 1'b0);
      end
      check_reset_vals("mid reset lat3");
      sel = 1'b0; #1;
      check_reset_vals("mid reset lat1");
      last_rd[0] = 16'h0000;
      last_rd[1] = 16'h0000;
      reset_n = 1'b1;

      // Held req is re-accepted as a fresh write after release.
      model(1'b1, 1'b1, 1'b0, 16'h0210, 16'h5A5A, e_rd, e_err, e_din);
      run_txn(1'b1, 1'b1, 1'b0, 16'h0210, 16'h5A5A, e_rd, e_err, e_din, "rst rewrite");
      model(1'b0, 1'b0, 1'b0, 16'h0210, 16'h0000, e_rd, e_err, e_din);
      run_txn(1'b0, 1'b0, 1'b0, 16'h0210, 16'h0000, e_rd, e_err, e_din, "rst readback");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram_sync_master.md
# ram_sync_master

Bus initiator for the synchronous 16-bit RAM. It accepts one CPU-side memory request at a time: a word or byte read or write. It drives the RAM's `rd`/`wr`/`byte_op`/`addr`/`data_in` lines for a fixed, parameterised number of cycles, then captures `data_out`. It returns the result with a single-cycle `ack`. It sits between the PDP-11 core's memory stage and the RAM and enforces PDP-11 odd-address rules.

## Interface
Parameters:
- `RD_LAT`, default 1: cycles `ram_rd` is held before `ram_data_out` is sampled (≥1).
- `WR_LAT`, default 1: cycles `ram_wr` is held (≥1).

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 1: request valid. Level signal, sampled only in IDLE with `ack` low.
- `we` in 1: 1 = write, 0 = read.
- `byte_op` in 1: 1 = byte access, 0 = word access.
- `addr` in 16: byte address.
- `wdata` in 16: write data. Byte writes use `[7:0]`.
- `rdata` out 16: read result, valid in the `ack` cycle and held until the next accept.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: odd-address error, valid with `ack`.
- `busy` out 1: high from accept through the `ack` cycle.
- `ram_addr` out 16: to RAM `addr`.
- `ram_data_in` out 16: to RAM `data_in`.
- `ram_data_out` in 16: from RAM `data_out`.
- `ram_rd` out 1: to RAM `rd`.
- `ram_wr` out 1: to RAM `wr`.
- `ram_byte_op` out 1: to RAM `byte_op`.

## Operation
- FSM states and transitions:
  - IDLE → ACCESS on an accepted request.
  - IDLE → FAULT on an accepted word request with `addr[0]`=1.
  - ACCESS → IDLE when the latency counter expires.
  - FAULT → IDLE after one cycle.
- Accept: in IDLE with `req`=1 and `ack`=0, latch `we`, `byte_op`, `addr`, `wdata`.
- Each request is executed once. The requester drops `req` on the edge where it sees `ack`; the mandatory `ack`=0 condition guarantees one gap cycle between requests.
- Odd word access: no RAM strobe is issued. `ack`=`err`=1 and `rdata` is unchanged.
- ACCESS, read: `ram_rd`=1 for `RD_LAT` cycles. `ram_data_out` is sampled on the final edge.
  - Word read: `rdata` = the 16-bit word.
  - Byte read: `rdata` = {8'h00, selected byte}; `addr[0]`=0 selects `[7:0]`, `addr[0]`=1 selects `[15:8]`. Sign extension is the core's job.
- ACCESS, write: `ram_wr`=1 for `WR_LAT` cycles.
  - Word write: `ram_data_in` = `wdata`.
  - Byte write: `ram_data_in` = {`wdata[7:0]`, `wdata[7:0]`}, so the RAM picks the lane from `addr[0]`.
  - `rdata` is unchanged.
- `ram_addr` = the latched `addr`, unmodified. `ram_byte_op` = the latched `byte_op`.
- All `ram_*` outputs are registered and stable for the whole strobe window. Outside ACCESS, `ram_rd`=`ram_wr`=0.

## Timing
- Reset values: FSM=IDLE; `ack`=`err`=`busy`=0; `ram_rd`=`ram_wr`=`ram_byte_op`=0; `ram_addr`=`ram_data_in`=`rdata`=0; counter=0.
- Accept at edge T: strobe high at edges T+1 … T+LAT. Sampling happens at edge T+LAT. `ack` is high in the cycle after edge T+LAT. Request→ack = LAT+1 cycles.
- Fault: `ack`/`err` high in the cycle after the accept edge (1 cycle).
- Back-to-back throughput: one transaction per LAT+2 cycles.
- Counter width: $clog2(max(`RD_LAT`,`WR_LAT`)+1). It counts down and wraps only via reload on accept.
- `req` is ignored while `busy`. Input changes during ACCESS have no effect.
- Reset asserted mid-ACCESS: strobes drop asynchronously and no `ack` is issued. After release, the FSM is in IDLE and a held `req` is re-accepted as a new request.

## Structure
- Shared package `ram_if_pkg`: FSM state encoding (IDLE, ACCESS, FAULT) and default latency constants. The `ram_sync` wrapper uses the same constants.
- One natural sub-module, `lat_counter`: a loadable down-counter with a `done` flag, parameterised by width.
- Everything else is a single always block for the FSM plus registered output logic.

## Test plan
- Word write then read, `RD_LAT`=`WR_LAT`=1: write 16'o123456 at 16'o1000, read back → `rdata`=16'o123456. `ack` arrives 2 cycles after each accept.
- Byte write/read with lanes: word 16'hFFFF at 16'h0200; byte write 8'h12 at 16'h0201 → `ram_data_in`=16'h1212. Byte reads return 16'h0012 at 0201 and 16'h00FF at 0200; word read returns 16'h12FF.
- Odd word read at 16'h0101 → no `ram_rd` pulse. `ack`=`err`=1 one cycle after accept, `rdata` unchanged.
- `RD_LAT`=3: `ram_rd` high exactly 3 cycles. RAM model data changed before the final edge is not captured; `ack` arrives 4 cycles after accept.
- `req` held high continuously across 3 reads → exactly 3 transactions, one idle gap cycle between each `ack` and the next accept.
- `reset_n` asserted during the 2nd cycle of a `WR_LAT`=3 write → `ram_wr` drops immediately, no `ack`. After release, all outputs are at reset values.
